// File: rtl/reg_bank_bus_scanner_pkg.sv
// Shared definitions for reg_bank_bus_scanner: FSM state encoding,
// bus-turnaround constant and parameter sizing helper.
package reg_bank_bus_scanner_pkg;

  // Scanner FSM states, 2-bit encoded.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } scan_state_e;

  // Cycles with every cs line released between capturing one register and
  // selecting the next one. The HOLD state provides exactly this gap.
  localparam int unsigned BUS_TURNAROUND_CYCLES = 1;

  // True when an index of idx_bits bits can address nr_regs registers.
  function automatic bit idx_bits_fit(input int unsigned idx_bits,
                                      input int unsigned nr_regs);
    return (64'd1 << idx_bits) >= 64'(nr_regs);
  endfunction

endpackage

// File: rtl/reg_bank_bus_scanner_cs_onehot_decoder.sv
// cs_onehot_decoder: turns a register index into active-low one-hot chip
// selects. With enable_i low, or an index past the bank, every line is
// released (all ones). Purely combinational.
module cs_onehot_decoder #(
  parameter int IdxBits  = 4,
  parameter int NrOfRegs = 16
) (
  input  logic [IdxBits-1:0]  idx_i,
  input  logic                enable_i,
  output logic [NrOfRegs-1:0] cs_n_o
);

  // Drive the single selected line low, all others high.
  always_comb begin
    // NOTE: assign the default first so every path writes cs_n_o; a missing
    // default in always_comb is what infers a latch.
    cs_n_o = '1;
    if (enable_i) begin
      for (int i = 0; i < NrOfRegs; i++) begin
        if (idx_i == IdxBits'(i)) begin
          cs_n_o[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/reg_bank_bus_scanner.sv
// reg_bank_bus_scanner: reads a bank of tri-state registers over one shared
// bus in index order and streams the captured values out over valid/ready.
// Per item: SEL drives one cs line low, the next Tick edge captures the bus,
// HOLD releases all cs lines (bus turnaround) while the item waits for the
// consumer. Everything advances only on edges where tick_i is high.
// Optional feature: define SCAN_ABORT_EN to add abort_i / aborted_o, which
// abandon a running scan and return to IDLE without a done pulse.
module reg_bank_bus_scanner
  import reg_bank_bus_scanner_pkg::*;
#(
  parameter int NrOfBits = 8,
  parameter int NrOfRegs = 16,
  parameter int IdxBits  = 4
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                tick_i,
  input  logic                start_i,
  input  logic [NrOfBits-1:0] bus_i,
  output logic [NrOfRegs-1:0] cs_n_o,
  output logic [NrOfBits-1:0] out_data_o,
  output logic [IdxBits-1:0]  out_index_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o,
`ifdef SCAN_ABORT_EN
  input  logic                abort_i,
  output logic                aborted_o,
`endif
  output logic                done_o
);

  // Reject parameter sets the index counter cannot address.
  if (!idx_bits_fit(IdxBits, NrOfRegs) || NrOfRegs < 2) begin : g_bad_params
    $error("reg_bank_bus_scanner: IdxBits too small for NrOfRegs, or NrOfRegs < 2");
  end
  if (BUS_TURNAROUND_CYCLES != 1) begin : g_bad_turnaround
    $error("reg_bank_bus_scanner: only a single HOLD turnaround cycle is implemented");
  end

  localparam logic [IdxBits-1:0] LAST_IDX = IdxBits'(NrOfRegs - 1);

  scan_state_e         state_q, state_d;
  logic [IdxBits-1:0]  idx_q, idx_d;
  logic [NrOfBits-1:0] out_data_q, out_data_d;
  logic [IdxBits-1:0]  out_index_q, out_index_d;
  logic                out_valid_q, out_valid_d;
`ifdef SCAN_ABORT_EN
  logic                aborted_q, aborted_d;
`endif

  // Next-state logic: FSM transitions, index counter and output capture.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
`ifdef SCAN_ABORT_EN
    aborted_d   = aborted_q;
`endif

    if (tick_i) begin
`ifdef SCAN_ABORT_EN
      aborted_d = 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            idx_d   = '0;
            state_d = ST_SEL;
          end
        end
        ST_SEL: begin
          // cs has been low for this cycle, so the bus carries register idx.
          out_data_d  = bus_i;
          out_index_d = idx_q;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready_i) begin
            out_valid_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + IdxBits'(1);
              state_d = ST_SEL;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

`ifdef SCAN_ABORT_EN
      // Abort overrides any transition, including a same-edge transfer.
      if (abort_i && state_q != ST_IDLE) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        aborted_d   = 1'b1;
      end
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
`ifdef SCAN_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
`ifdef SCAN_ABORT_EN
      aborted_q   <= aborted_d;
`endif
    end
  end

  // Chip selects are decoded from state and index, so a held SEL keeps its
  // cs line low across Tick=0 cycles and HOLD always releases the bus.
  cs_onehot_decoder #(
    .IdxBits  (IdxBits),
    .NrOfRegs (NrOfRegs)
  ) u_cs_decoder (
    .idx_i    (idx_q),
    .enable_i (state_q == ST_SEL),
    .cs_n_o   (cs_n_o)
  );

  assign out_data_o  = out_data_q;
  assign out_index_o = out_index_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
`ifdef SCAN_ABORT_EN
  assign aborted_o   = aborted_q;
`endif

endmodule

// File: tb/tb_reg_bank_bus_scanner.sv
// Self-checking bench for reg_bank_bus_scanner. A register-bank model drives
// the shared bus from the cs lines; the expected item stream for each scan
// is queued at start and a negedge monitor pops and compares on every
// transfer, alongside cs, hold-on-Tick=0 and output-stability invariants.
// Define SCAN_ABORT_EN for both RTL and bench to exercise abort.
module tb_reg_bank_bus_scanner;

  localparam int NB = 8;
  localparam int NR = 16;
  localparam int IB = 4;
  localparam logic [NR-1:0] ALL1 = '1;

  typedef struct packed {
    logic [IB-1:0] idx;
    logic [NB-1:0] data;
  } item_t;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          tick_i = 1'b1;
  logic          start_i = 1'b0;
  logic          out_ready_i = 1'b1;
  logic          abort_i = 1'b0;
  logic [NB-1:0] bus_i;
  logic [NR-1:0] cs_n_o;
  logic [NB-1:0] out_data_o;
  logic [IB-1:0] out_index_o;
  logic          out_valid_o;
  logic          busy_o;
  logic          done_o;
`ifdef SCAN_ABORT_EN
  logic          aborted_o;
`endif

  logic [NB-1:0] bank [NR];
  logic [NB-1:0] junk = 8'hA5;
  item_t         exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int tick_mode = 0;     // 0: always, 1: one edge in three, 2: random
  bit rdy_random = 1'b0;
  int stall_idx = -1;
  int stall_left = 0;
  int cyc = 0;
  int done_count = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  reg_bank_bus_scanner #(
    .NrOfBits (NB),
    .NrOfRegs (NR),
    .IdxBits  (IB)
  ) dut (
    .clock_i     (clk),
    .reset_i     (reset_i),
    .tick_i      (tick_i),
    .start_i     (start_i),
    .bus_i       (bus_i),
    .cs_n_o      (cs_n_o),
    .out_data_o  (out_data_o),
    .out_index_o (out_index_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
`ifdef SCAN_ABORT_EN
    .abort_i     (abort_i),
    .aborted_o   (aborted_o),
`endif
    .done_o      (done_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register bank: the selected register drives the bus. Outside Tick edges
  // the bus carries junk, so only a value sampled on a Tick edge is correct.
  always_comb begin
    bus_i = junk;
    if (tick_i) begin
      for (int i = 0; i < NR; i++) begin
        if (!cs_n_o[i]) bus_i = bank[i];
      end
    end
  end

  // Per-cycle drive of Tick, OutReady and bus junk, just after each edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    junk = 8'($urandom);
    case (tick_mode)
      0:       tick_i = 1'b1;
      1:       tick_i = (cyc % 3 == 0);
      default: tick_i = 1'($urandom_range(0, 1));
    endcase
    if (stall_left > 0 && out_valid_o && 32'(out_index_o) == stall_idx) begin
      out_ready_i = 1'b0;
      stall_left--;
    end else if (rdy_random) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready_i = 1'b1;
    end
  end

  // Monitor: scoreboard pops plus invariants, sampled on the falling edge.
  logic [31:0] p_vec;
  logic [NB-1:0] p_data;
  logic [IB-1:0] p_index;
  logic p_valid, p_tick, p_reset, p_xfer, p_done;
  bit   p_ok = 1'b0;

  always @(negedge clk) begin
    logic  xfer;
    item_t e;
    if (!mon_en) begin
      p_ok = 1'b0;
    end else begin
      check("cs_at_most_one_low", 32'($countones(~cs_n_o) <= 1), 32'd1);
      if (out_valid_o || !busy_o) check("cs_released", 32'(cs_n_o), 32'(ALL1));
      if (p_ok && !p_tick && !p_reset)
        check("hold_without_tick",
              32'({cs_n_o, out_data_o, out_index_o, out_valid_o, busy_o, done_o}), p_vec);
      if (p_ok && p_valid && out_valid_o && !p_xfer && !p_reset)
        check("valid_item_stable", 32'({out_data_o, out_index_o}), 32'({p_data, p_index}));
      if (p_ok && done_o && !p_done) done_count++;

      xfer = out_valid_o && out_ready_i && tick_i && !reset_i && !abort_i;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          check("unexpected_item", 32'(out_index_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("item_index", 32'(out_index_o), 32'(e.idx));
          check("item_data", 32'(out_data_o), 32'(e.data));
        end
      end

      p_vec   = 32'({cs_n_o, out_data_o, out_index_o, out_valid_o, busy_o, done_o});
      p_data  = out_data_o;
      p_index = out_index_o;
      p_valid = out_valid_o;
      p_tick  = tick_i;
      p_reset = reset_i;
      p_xfer  = xfer;
      p_done  = done_o;
      p_ok    = 1'b1;
    end
  end

  // Stimulus acts 2 time units after each rising edge, after the drivers.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load_bank(input bit incrementing);
    for (int i = 0; i < NR; i++) bank[i] = incrementing ? 8'(8'h10 + i) : 8'($urandom);
  endtask

  task automatic push_scan();
    for (int i = 0; i < NR; i++) exp_q.push_back('{idx: IB'(i), data: bank[i]});
  endtask

  // One full scan; edges counts rising edges from Start up to Done visible.
  // poke_start re-pulses Start while busy and during the DONE cycle.
  task automatic run_scan(input bit poke_start, output int edges, output int stall_seen);
    int  d0;
    bit  seen_done;
    d0 = done_count;
    edges = 0;
    stall_seen = 0;
    seen_done = 1'b0;
    push_scan();
    start_i = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      edges++;
      if (busy_o) start_i = 1'b0;
      if (poke_start && busy_o && (edges == 5 || edges == 12)) start_i = 1'b1;
      if (stall_idx >= 0 && out_valid_o && 32'(out_index_o) == stall_idx && !out_ready_i) begin
        stall_seen++;
        check("stall_cs_released", 32'(cs_n_o), 32'(ALL1));
        check("stall_data", 32'(out_data_o), 32'(bank[stall_idx]));
      end
      if (done_o) begin
        seen_done = 1'b1;
        break;
      end
    end
    check("scan_reaches_done", 32'(seen_done), 32'd1);
    if (poke_start) start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 0; c < 50 && busy_o; c++) step();
    repeat (3) begin
      step();
      check("idle_after_scan", 32'(busy_o), 32'd0);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("one_done_pulse", 32'(done_count - d0), 32'd1);
    exp_q.delete();
  endtask

  initial begin
    int  edges, stall_seen, d0;
    bit  found;

    // Reset state.
    repeat (3) step();
    check("rst_cs_n", 32'(cs_n_o), 32'(ALL1));
    check("rst_data", 32'(out_data_o), 32'd0);
    check("rst_index", 32'(out_index_o), 32'd0);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    reset_i = 1'b0;
    mon_en  = 1'b1;
    step();

    // Full-speed scan: Done visible 2*NR+1 edges after Start.
    load_bank(1'b1);
    run_scan(1'b0, edges, stall_seen);
    check("scan_edge_count", 32'(edges), 32'(2 * NR + 1));

    // Consumer stalls item 3 for five cycles.
    load_bank(1'b1);
    stall_idx = 3;
    stall_left = 5;
    run_scan(1'b0, edges, stall_seen);
    check("stall_cycles", 32'(stall_seen), 32'd5);
    stall_idx = -1;

    // Tick on one edge in three.
    tick_mode = 1;
    load_bank(1'b0);
    run_scan(1'b0, edges, stall_seen);
    check("slow_tick_longer", 32'(edges > 2 * (2 * NR + 1)), 32'd1);
    tick_mode = 0;

    // Reset while item 9 waits in HOLD.
    load_bank(1'b0);
    push_scan();
    stall_idx = 9;
    stall_left = 3;
    start_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      step();
      if (busy_o) start_i = 1'b0;
      if (out_valid_o && out_index_o == 4'd9) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_idx9_hold", 32'(found), 32'd1);
    d0 = done_count;
    reset_i = 1'b1;
    step();
    check("midrst_cs_n", 32'(cs_n_o), 32'(ALL1));
    check("midrst_valid", 32'(out_valid_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_data", 32'(out_data_o), 32'd0);
    reset_i = 1'b0;
    exp_q.delete();
    stall_left = 0;
    stall_idx = -1;
    repeat (4) step();
    check("midrst_no_done", 32'(done_count - d0), 32'd0);
    check("midrst_stays_idle", 32'(busy_o), 32'd0);

    // Start while busy and in the DONE cycle is ignored.
    load_bank(1'b0);
    run_scan(1'b1, edges, stall_seen);
    check("poke_edge_count", 32'(edges), 32'(2 * NR + 1));

    // Randomized Tick and OutReady.
    tick_mode = 2;
    rdy_random = 1'b1;
    for (int s = 0; s < 3; s++) begin
      load_bank(1'b0);
      run_scan(1'b0, edges, stall_seen);
    end
    tick_mode = 0;
    rdy_random = 1'b0;
    step();

`ifdef SCAN_ABORT_EN
    // Abort while item 5 is selected.
    load_bank(1'b0);
    push_scan();
    start_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      step();
      if (busy_o) start_i = 1'b0;
      if (!cs_n_o[5]) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_sel5", 32'(found), 32'd1);
    d0 = done_count;
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_cs_n", 32'(cs_n_o), 32'(ALL1));
    check("abort_valid", 32'(out_valid_o), 32'd0);
    check("abort_pulse", 32'(aborted_o), 32'd1);
    exp_q.delete();
    step();
    check("abort_pulse_ends", 32'(aborted_o), 32'd0);
    repeat (3) step();
    check("abort_no_done", 32'(done_count - d0), 32'd0);
`endif

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Bound on total runtime.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time bound, errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
